// File: rtl/fwd_pkg.sv
// Shared types for the EX-stage forwarding and load-use hazard controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fwd_pkg;

  // Width of a register index carried in a pipeline tag.
  localparam int TAG_W = 5;

  // Hard-zero register (XZR): never forwarded, never a stall source.
  localparam logic [TAG_W-1:0] XZR = 5'd31;

  // {sel1, sel0} encoding of the EX operand-select muxes.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,  // register file read
    FWD_EX  = 2'b01,  // EX/MEM ALU result
    FWD_MEM = 2'b10,  // MEM/WB writeback data
    FWD_IMM = 2'b11   // immediate, operand B only
  } fwd_sel_e;

  // Destination tag tracked for an in-flight instruction.
  typedef struct packed {
    logic [TAG_W-1:0] rd;
    logic             wr;
    logic             ld;
  } pipe_tag_t;

  // Tag of an empty pipeline slot.
  localparam pipe_tag_t BUBBLE_TAG = '{rd: '0, wr: 1'b0, ld: 1'b0};

endpackage

// File: rtl/fwd_src_cmp.sv
// Compares one ID-stage source register against the EX and MEM destination tags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether a hit stalls or forwards.
module fwd_src_cmp
  import fwd_pkg::*;
#(
  parameter int REG_W    = TAG_W,
  parameter int ZERO_REG = 31
) (
  input  logic [REG_W-1:0] src_i,
  input  logic             use_i,
  input  pipe_tag_t        ex_tag_i,
  input  pipe_tag_t        mem_tag_i,
  output logic             ex_hit_o,
  output logic             mem_hit_o,
  output fwd_sel_e         sel_o
);

  logic src_live;
  logic unused_ld_bits;

  // A source only participates when it is really read and is not the zero register.
  assign src_live = use_i && (src_i != REG_W'(ZERO_REG));

  assign ex_hit_o  = src_live && ex_tag_i.wr  && (ex_tag_i.rd  == src_i);
  assign mem_hit_o = src_live && mem_tag_i.wr && (mem_tag_i.rd == src_i);

  // Load flags matter to the stall decision in the parent, not to the select.
  assign unused_ld_bits = ex_tag_i.ld ^ mem_tag_i.ld;

  // EX wins over MEM: the instruction in EX holds the newest value of the register.
  always_comb begin
    sel_o = FWD_RF;
    if (ex_hit_o) begin
      sel_o = FWD_EX;
    end else if (mem_hit_o) begin
      sel_o = FWD_MEM;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall controller for the EX operand muxes.
// Latency: selects registered, valid for the cycle after ID; stall combinational.
// Backpressure: stall holds PC and IF/ID for one cycle; FWD_STALL_CNT_EN adds stall_count.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_W    = TAG_W,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_imm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0]      stall_count
`endif
);

  // Destination tags of the instructions currently in EX and MEM.
  pipe_tag_t ex_q, ex_d;
  pipe_tag_t mem_q, mem_d;
  pipe_tag_t id_tag;

  // Registered mux selects presented during the EX cycle.
  fwd_sel_e a_sel_q, a_sel_d;
  fwd_sel_e b_sel_q, b_sel_d;

  fwd_sel_e a_cmp_sel, b_cmp_sel;
  logic     a_ex_hit, a_mem_hit;
  logic     b_ex_hit, b_mem_hit;
  logic     load_use;
  logic     insert_bubble;
  logic     unused_mem_hits;

  assign id_tag = '{rd: id_rd, wr: id_reg_write, ld: id_mem_read};

  fwd_src_cmp #(
    .REG_W    (REG_W),
    .ZERO_REG (ZERO_REG)
  ) u_cmp_rn (
    .src_i     (id_rn),
    .use_i     (id_use_rn),
    .ex_tag_i  (ex_q),
    .mem_tag_i (mem_q),
    .ex_hit_o  (a_ex_hit),
    .mem_hit_o (a_mem_hit),
    .sel_o     (a_cmp_sel)
  );

  fwd_src_cmp #(
    .REG_W    (REG_W),
    .ZERO_REG (ZERO_REG)
  ) u_cmp_rm (
    .src_i     (id_rm),
    .use_i     (id_use_rm),
    .ex_tag_i  (ex_q),
    .mem_tag_i (mem_q),
    .ex_hit_o  (b_ex_hit),
    .mem_hit_o (b_mem_hit),
    .sel_o     (b_cmp_sel)
  );

  // MEM hits are already folded into the per-source select.
  assign unused_mem_hits = a_mem_hit | b_mem_hit;

  // A load in EX has no data until MEM, so a consumer right behind it must wait one cycle.
  assign load_use = ex_q.ld && (a_ex_hit || b_ex_hit);

  // A taken-branch flush kills the consumer, so it must never also stall.
  assign stall = id_valid && !flush && load_use;

  assign insert_bubble = stall || flush || !id_valid;

  // Next-state for the tag pipeline and the operand selects.
  always_comb begin
    mem_d   = ex_q;
    ex_d    = insert_bubble ? BUBBLE_TAG : id_tag;
    a_sel_d = a_cmp_sel;
    b_sel_d = id_use_imm ? FWD_IMM : b_cmp_sel;
    if (stall || flush) begin
      a_sel_d = FWD_RF;
      b_sel_d = FWD_RF;
    end
  end

  // Tag and select registers; reset drops every pending forward in one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q    <= BUBBLE_TAG;
      mem_q   <= BUBBLE_TAG;
      a_sel_q <= FWD_RF;
      b_sel_q <= FWD_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      a_sel_q <= a_sel_d;
      b_sel_q <= b_sel_d;
    end
  end

  assign fwd_a_sel = a_sel_q;
  assign fwd_b_sel = b_sel_q;

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles; sticks at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed instruction stream, queued expectations.
// Latency: stall checked in the issue cycle, selects and stall_count one cycle later.
// Backpressure: the driver re-issues a stalled instruction itself.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rn, id_rm, id_rd;
  logic        id_use_rn, id_use_rm, id_use_imm;
  logic        id_reg_write, id_mem_read;
  logic        flush;
  logic        stall;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_count;
  logic [31:0] cnt_model;
`endif

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] expv;
    string       name;
  } chk_t;

  chk_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_use_rn    (id_use_rn),
    .id_use_rm    (id_use_rm),
    .id_use_imm   (id_use_imm),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .stall        (stall),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel)
`ifdef FWD_STALL_CNT_EN
    ,
    .stall_count  (stall_count)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int due, input int kind, input logic [31:0] expv, input string nm);
    chk_t c;
    c.due  = due;
    c.kind = kind;
    c.expv = expv;
    c.name = nm;
    sbq.push_back(c);
  endtask

  // Monitor: every entry due this cycle is compared at the falling edge.
  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] act;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      c   = sbq.pop_front();
      act = 32'd0;
      case (c.kind)
        0:       act = {31'd0, stall};
        1:       act = {28'd0, fwd_a_sel, fwd_b_sel};
`ifdef FWD_STALL_CNT_EN
        default: act = stall_count;
`else
        default: act = 32'd0;
`endif
      endcase
      checks++;
      if (c.due != cyc || act !== c.expv) begin
        errors++;
        $display("FAIL %s: got %h, expected %h (cycle %0d, due %0d)", c.name, act, c.expv, cyc, c.due);
      end
    end
  end

  // One ID-stage cycle; sel expectation is {a,b}.
  task automatic issue(input string nm, input logic rst, input logic vld,
                       input logic [4:0] rn, input logic [4:0] rm,
                       input logic urn, input logic urm, input logic uimm,
                       input logic [4:0] rd, input logic wr, input logic ld, input logic fl,
                       input logic es, input logic [1:0] ea, input logic [1:0] eb);
    @(posedge clk);
    #1;
    reset        = rst;
    id_valid     = vld;
    id_rn        = rn;
    id_rm        = rm;
    id_use_rn    = urn;
    id_use_rm    = urm;
    id_use_imm   = uimm;
    id_rd        = rd;
    id_reg_write = wr;
    id_mem_read  = ld;
    flush        = fl;
    push(cyc, 0, {31'd0, es}, {nm, "/stall"});
    push(cyc + 1, 1, {28'd0, ea, eb}, {nm, "/sel"});
`ifdef FWD_STALL_CNT_EN
    if (rst) cnt_model = 32'd0;
    else if (es && cnt_model != 32'hFFFF_FFFF) cnt_model = cnt_model + 32'd1;
    push(cyc + 1, 2, cnt_model, {nm, "/stall_count"});
`endif
  endtask

  task automatic ins(input string nm, input logic [4:0] rn, input logic [4:0] rm,
                     input logic urn, input logic urm, input logic uimm,
                     input logic [4:0] rd, input logic wr, input logic ld, input logic fl,
                     input logic es, input logic [1:0] ea, input logic [1:0] eb);
    issue(nm, 1'b0, 1'b1, rn, rm, urn, urm, uimm, rd, wr, ld, fl, es, ea, eb);
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_rn = '0; id_rm = '0; id_rd = '0;
    id_use_rn = 1'b0; id_use_rm = 1'b0; id_use_imm = 1'b0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0;
`ifdef FWD_STALL_CNT_EN
    cnt_model = 32'd0;
`endif
    //     name         rst vld rn     rm     urn  urm  uimm rd     wr   ld   fl   stall a      b
    issue("reset0",     1,  0,  5'd0,  5'd0,  0,   0,   0,   5'd0,  0,   0,   0,   0,    2'b00, 2'b00);
    issue("reset1",     1,  0,  5'd0,  5'd0,  0,   0,   0,   5'd0,  0,   0,   0,   0,    2'b00, 2'b00);
    // back-to-back ALU forward, distance-2 forward, EX priority
    ins("add_x1",       5'd10, 5'd11, 1, 1, 0, 5'd1,  1, 0, 0, 0, 2'b00, 2'b00);
    ins("sub_fwd_ex",   5'd1,  5'd12, 1, 1, 0, 5'd2,  1, 0, 0, 0, 2'b01, 2'b00);
    ins("orr_unrel",    5'd13, 5'd14, 1, 1, 0, 5'd4,  1, 0, 0, 0, 2'b00, 2'b00);
    ins("and_fwd_mem",  5'd15, 5'd2,  1, 1, 0, 5'd5,  1, 0, 0, 0, 2'b00, 2'b10);
    ins("add_x6_a",     5'd20, 5'd21, 1, 1, 0, 5'd6,  1, 0, 0, 0, 2'b00, 2'b00);
    ins("add_x6_b",     5'd22, 5'd23, 1, 1, 0, 5'd6,  1, 0, 0, 0, 2'b00, 2'b00);
    ins("ex_priority",  5'd6,  5'd6,  1, 1, 0, 5'd7,  1, 0, 0, 0, 2'b01, 2'b01);
    // load-use on rn
    ins("ldur_x3",      5'd24, 5'd0,  1, 0, 1, 5'd3,  1, 1, 0, 0, 2'b00, 2'b11);
    ins("lu_rn_stall",  5'd3,  5'd25, 1, 1, 0, 5'd8,  1, 0, 0, 1, 2'b00, 2'b00);
    ins("lu_rn_retry",  5'd3,  5'd25, 1, 1, 0, 5'd8,  1, 0, 0, 0, 2'b10, 2'b00);
    // immediate overrides an EX match; zero register never forwards or stalls
    ins("addi_imm",     5'd20, 5'd8,  1, 1, 1, 5'd9,  1, 0, 0, 0, 2'b00, 2'b11);
    ins("wr_x31",       5'd1,  5'd2,  1, 1, 0, 5'd31, 1, 0, 0, 0, 2'b00, 2'b00);
    ins("rd_x31_ex",    5'd31, 5'd31, 1, 1, 0, 5'd10, 1, 0, 0, 0, 2'b00, 2'b00);
    ins("rd_x31_mem",   5'd31, 5'd10, 1, 1, 0, 5'd11, 1, 0, 0, 0, 2'b00, 2'b01);
    ins("ldur_x31",     5'd24, 5'd0,  1, 0, 1, 5'd31, 1, 1, 0, 0, 2'b00, 2'b11);
    ins("x31_no_stall", 5'd31, 5'd26, 1, 1, 0, 5'd12, 1, 0, 0, 0, 2'b00, 2'b00);
    // flush beats stall and bubbles EX
    ins("ldur_x13",     5'd24, 5'd0,  1, 0, 1, 5'd13, 1, 1, 0, 0, 2'b00, 2'b11);
    ins("flush_lu",     5'd13, 5'd13, 1, 1, 0, 5'd14, 1, 0, 1, 0, 2'b00, 2'b00);
    ins("after_flush",  5'd14, 5'd13, 1, 1, 0, 5'd15, 1, 0, 0, 0, 2'b00, 2'b10);
    // unused source, invalid slot becomes a bubble
    ins("movz_no_rn",   5'd15, 5'd0,  0, 0, 1, 5'd16, 1, 0, 0, 0, 2'b00, 2'b11);
    issue("idle_slot",  0,  0,  5'd0,  5'd0,  0,   0,   0,   5'd20, 1,   0,   0,   0,    2'b00, 2'b00);
    ins("after_idle",   5'd20, 5'd16, 1, 1, 0, 5'd21, 1, 0, 0, 0, 2'b00, 2'b10);
    // load-use on rm
    ins("ldur_x17",     5'd24, 5'd0,  1, 0, 1, 5'd17, 1, 1, 0, 0, 2'b00, 2'b11);
    ins("lu_rm_stall",  5'd26, 5'd17, 1, 1, 0, 5'd18, 1, 0, 0, 1, 2'b00, 2'b00);
    ins("lu_rm_retry",  5'd26, 5'd17, 1, 1, 0, 5'd18, 1, 0, 0, 0, 2'b00, 2'b10);
    // reset mid-stream with a pending producer
    ins("add_x5",       5'd27, 5'd28, 1, 1, 0, 5'd5,  1, 0, 0, 0, 2'b00, 2'b00);
    issue("mid_reset",  1,  1,  5'd5,  5'd5,  1,   1,   0,   5'd22, 1,   0,   0,   0,    2'b00, 2'b00);
    ins("post_reset",   5'd5,  5'd5,  1, 1, 0, 5'd23, 1, 0, 0, 0, 2'b00, 2'b00);
    issue("drain",      0,  0,  5'd0,  5'd0,  0,   0,   0,   5'd0,  0,   0,   0,   0,    2'b00, 2'b00);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
